// File: rtl/frame_memory_reader.sv
// Purpose: fetches one frame from memory with a single INCR read burst and replays it as an AXI-Stream video stream.
// Latency: start_read one cycle after frame_ready; each accepted beat reaches m_axis_tdata one cycle after its handshake.
// Backpressure: m_axis_tready stalls the output FIFO; a full FIFO drops read_ready until a pixel leaves.
//
// Ports:
//   clk, rst_n                     clock, asynchronous active-low reset
//   frame_ready, base_addr_in      frame request pulse and its base address
//   pixels_per_frame, frame_width, frame_height   frame geometry, held stable while a frame is in flight
//   start_read, read_addr, read_len, read_size, read_burst   burst request (one-cycle start_read)
//   read_data, read_valid, read_ready                        read beat channel
//   m_axis_tdata/tvalid/tready/tlast/tuser                   pixel stream (tlast = end of line, tuser = start of frame)
//   frame_done, busy                                         end-of-frame pulse, not-idle indicator
module frame_memory_reader #(
  parameter int ADDR_WIDTH = 32,
  parameter int DATA_WIDTH = 32,
  parameter int FIFO_DEPTH = 4
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  frame_ready,
  input  logic [ADDR_WIDTH-1:0] base_addr_in,
  input  logic [31:0]           pixels_per_frame,
  input  logic [15:0]           frame_width,
  input  logic [15:0]           frame_height,
  output logic                  start_read,
  output logic [ADDR_WIDTH-1:0] read_addr,
  output logic [31:0]           read_len,
  output logic [2:0]            read_size,
  output logic [1:0]            read_burst,
  input  logic [DATA_WIDTH-1:0] read_data,
  input  logic                  read_valid,
  output logic                  read_ready,
  output logic [DATA_WIDTH-1:0] m_axis_tdata,
  output logic                  m_axis_tvalid,
  input  logic                  m_axis_tready,
  output logic                  m_axis_tlast,
  output logic                  m_axis_tuser,
  output logic                  frame_done,
  output logic                  busy
);

  localparam int PTR_W = $clog2(FIFO_DEPTH);
  localparam int CNT_W = PTR_W + 1;

  typedef enum logic [1:0] {IDLE, START, STREAM, DONE} state_t;

  state_t                state;
  logic [ADDR_WIDTH-1:0] cur_base;
  logic [ADDR_WIDTH-1:0] pend_base;
  logic                  pending;
  logic [31:0]           beats_rx;
  logic [15:0]           col;
  logic [15:0]           row;

  logic [DATA_WIDTH-1:0] fifo_mem [FIFO_DEPTH];
  logic [PTR_W-1:0]      wr_ptr;
  logic [PTR_W-1:0]      rd_ptr;
  logic [CNT_W-1:0]      count;

  logic fifo_full;
  logic fifo_empty;
  logic push;
  logic pop;
  logic col_last;
  logic row_last;

  assign fifo_full  = (count == CNT_W'(FIFO_DEPTH));
  assign fifo_empty = (count == '0);

  // Beats beyond the frame length are never accepted, so the memory may over-supply.
  assign read_ready = (state == STREAM) && !fifo_full && (beats_rx < pixels_per_frame);
  assign push       = read_valid && read_ready;
  assign pop        = !fifo_empty && m_axis_tready;

  assign col_last = (col == frame_width - 16'd1);
  assign row_last = (row == frame_height - 16'd1);

  // Head is gated so the stream bus reads zero whenever nothing is buffered (including reset).
  assign m_axis_tvalid = !fifo_empty;
  assign m_axis_tdata  = fifo_empty ? '0 : fifo_mem[rd_ptr];
  assign m_axis_tuser  = m_axis_tvalid && (row == 16'd0) && (col == 16'd0);
  assign m_axis_tlast  = m_axis_tvalid && col_last;

  // Burst qualifiers are only non-zero during the single START cycle.
  assign read_addr  = cur_base;
  assign read_len   = start_read ? pixels_per_frame : 32'd0;
  assign read_size  = 3'd2;
  assign read_burst = {1'b0, start_read};

  always_ff @(posedge clk) begin
    if (push) begin
      fifo_mem[wr_ptr] <= read_data;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (push) begin
        wr_ptr <= wr_ptr + PTR_W'(1);
      end
      if (pop) begin
        rd_ptr <= rd_ptr + PTR_W'(1);
      end
      case ({push, pop})
        2'b10:   count <= count + CNT_W'(1);
        2'b01:   count <= count - CNT_W'(1);
        default: count <= count;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state      <= IDLE;
      cur_base   <= '0;
      pend_base  <= '0;
      pending    <= 1'b0;
      beats_rx   <= '0;
      col        <= '0;
      row        <= '0;
      start_read <= 1'b0;
      frame_done <= 1'b0;
      busy       <= 1'b0;
    end else begin
      start_read <= 1'b0;
      frame_done <= 1'b0;

      // Requests arriving while a frame is in flight are remembered; the newest one wins.
      if (frame_ready && (state != IDLE)) begin
        pending   <= 1'b1;
        pend_base <= base_addr_in;
      end

      case (state)
        IDLE: begin
          // A fresh request supersedes a queued one, so pending is dropped either way.
          if (frame_ready || pending) begin
            cur_base   <= frame_ready ? base_addr_in : pend_base;
            pending    <= 1'b0;
            beats_rx   <= '0;
            col        <= '0;
            row        <= '0;
            start_read <= 1'b1;
            busy       <= 1'b1;
            state      <= START;
          end
        end

        START: begin
          state <= STREAM;
        end

        STREAM: begin
          if (push) begin
            beats_rx <= beats_rx + 32'd1;
          end
          if (pop) begin
            if (col_last) begin
              col <= '0;
              if (row_last) begin
                frame_done <= 1'b1;
                state      <= DONE;
              end else begin
                row <= row + 16'd1;
              end
            end else begin
              col <= col + 16'd1;
            end
          end
        end

        DONE: begin
          busy  <= 1'b0;
          state <= IDLE;
        end

        default: begin
          state <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: doc/frame_memory_reader.md
FRAME_MEMORY_READER -- requirements
Module: frame_memory_reader

Interface
REQ-001 Parameters, one per line: name, default, meaning:
  ADDR_WIDTH  32  memory address width
  DATA_WIDTH  32  pixel word width
  FIFO_DEPTH  4   output buffer entries, power of 2, >=2
REQ-002 Ports, one per line: name  direction  width  meaning:
  clk  in  1  clock
  rst_n  in  1  reset, asynchronous, active-low
  frame_ready  in  1  one-cycle pulse: a frame is complete in memory
  base_addr_in  in  ADDR_WIDTH  frame base address, valid with frame_ready
  pixels_per_frame  in  32  pixels per frame, max 1280*720
  frame_width  in  16  pixels per line, 1..1280
  frame_height  in  16  lines per frame, 1..720
  start_read  out  1  one-cycle read-burst request to the AXI memory
  read_addr  out  ADDR_WIDTH  burst start address
  read_len  out  32  burst length in beats
  read_size  out  3  beat size, log2 bytes
  read_burst  out  2  burst type
  read_data  in  DATA_WIDTH  read beat data
  read_valid  in  1  read beat valid
  read_ready  out  1  read beat accepted
  m_axis_tdata  out  DATA_WIDTH  pixel
  m_axis_tvalid  out  1  pixel valid
  m_axis_tready  in  1  downstream ready
  m_axis_tlast  out  1  last pixel of line
  m_axis_tuser  out  1  first pixel of frame
  frame_done  out  1  one-cycle pulse after the last pixel handshake
  busy  out  1  high in every state except IDLE

Function
REQ-003 The FSM SHALL have the states IDLE, START, STREAM and DONE.
REQ-004 IDLE: on frame_ready=1 (or pending=1), latch the base address into cur_base, clear the counters, and go to START next cycle.
REQ-005 START, exactly one cycle: start_read=1, read_addr=cur_base, read_len=pixels_per_frame, read_size=2, read_burst=1 (INCR); then go to STREAM.
REQ-006 Outside START: start_read=0, read_addr=cur_base, read_len=0, read_size=2, read_burst=0.
REQ-007 In STREAM, read_ready SHALL be 1 only when the FIFO is not full and beats_rx < pixels_per_frame; it SHALL be 0 in all other states.
REQ-008 A read beat SHALL be pushed into the FIFO iff read_valid & read_ready; each push increments beats_rx (32 bit).
REQ-009 m_axis_tvalid = FIFO not empty, and m_axis_tdata = FIFO head (first-word fall-through).
REQ-010 A pop SHALL occur iff m_axis_tvalid & m_axis_tready; pixel data SHALL NOT change while tvalid=1 and tready=0.
REQ-011 A simultaneous push and pop SHALL leave the FIFO count unchanged; no push occurs when full; no pop occurs when empty.
REQ-012 The col counter (16 bit) and row counter (16 bit) SHALL advance on each pop; at col=frame_width-1, col wraps to 0 and row increments.
REQ-013 m_axis_tuser = tvalid & row==0 & col==0.
REQ-014 m_axis_tlast = tvalid & col==frame_width-1.
REQ-015 On the pop at row=frame_height-1 and col=frame_width-1, go to DONE.
REQ-016 DONE, one cycle: frame_done=1, then go to IDLE.
REQ-017 When frame_ready=1 while busy, set pending=1 and latch pend_base; a second request while pending=1 overwrites pend_base.
REQ-018 When the IDLE exit is served from pending, pending SHALL clear and cur_base=pend_base; a new frame_ready in that same cycle takes priority over the pending request.
REQ-019 Read beats in excess of pixels_per_frame SHALL NOT be accepted; the FIFO SHALL be empty on entry to DONE.

Reset
REQ-020 Asynchronous assertion of rst_n=0 SHALL force: state=IDLE, FIFO empty, all counters=0, pending=0, cur_base=0.
REQ-021 In reset, all outputs SHALL be 0, except read_size=2.
REQ-022 Reset mid-frame SHALL abandon the burst with no frame_done; the first frame_ready after release SHALL restart cleanly.

Verification
REQ-023 4x2 frame, base 0x100, read_valid and tready held high -> start_read one cycle with addr 0x100 and len 8; 8 pixels; tuser on pixel 0; tlast on pixels 3 and 7; frame_done one cycle after pixel 7.
REQ-024 tready=0 for 10 cycles mid-line -> FIFO fills to 4; read_ready=0; tdata stable; no pixel lost or duplicated.
REQ-025 Memory supplies 12 beats for an 8-pixel frame -> exactly 8 beats accepted; read_ready=0 after beat 8.
REQ-026 Second frame_ready (base 0x200) during STREAM -> after frame_done, IDLE for one cycle, then START with addr 0x200.
REQ-027 rst_n pulsed low at pixel 5 of 8 -> all outputs 0 at once (read_size=2); a fresh frame then completes normally.
REQ-028 1x1 frame -> a single pixel with tuser=1 and tlast=1, followed by frame_done.
